// File: rtl/branch_feedback_queue.sv
// In-order queue of in-flight conditional branches; emits one registered
// predictor-feedback beat per resolution and squashes wrong-path entries on a mispredict.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

`ifndef MIPS_CORE_PKG_DEFINED
`define MIPS_CORE_PKG_DEFINED
package mips_core_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;
endpackage
`endif

module branch_feedback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_alloc_valid,
  input  logic [`ADDR_WIDTH-1:0]     i_alloc_pc,
  input  mips_core_pkg::BranchOutcome i_alloc_prediction,
  output logic                       o_alloc_ready,
  input  logic                       i_res_valid,
  input  mips_core_pkg::BranchOutcome i_res_outcome,
  input  logic                       i_flush,
  output logic                       o_fb_valid,
  output logic [`ADDR_WIDTH-1:0]     o_fb_pc,
  output mips_core_pkg::BranchOutcome o_fb_prediction,
  output mips_core_pkg::BranchOutcome o_fb_outcome,
  output logic                       o_mispredict,
  output logic [$clog2(DEPTH):0]     o_count
);
  import mips_core_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [`ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  BranchOutcome           pred_mem [DEPTH];

  logic [PTR_W-1:0] head_p0, tail_p0;
  logic [PTR_W:0]   count_p0;

  logic [PTR_W-1:0] head_next, tail_next;
  logic [PTR_W:0]   count_next;
  logic             res_acc, alloc_acc, mis, squash;
  logic [`ADDR_WIDTH-1:0] head_pc;
  BranchOutcome           head_pred;

  logic                   fb_valid_p1, mispredict_p1;
  logic [`ADDR_WIDTH-1:0] fb_pc_p1;
  BranchOutcome           fb_pred_p1, fb_out_p1;

  assign o_alloc_ready = (count_p0 != (PTR_W+1)'(DEPTH));
  assign o_count       = count_p0;

  assign head_pc   = pc_mem[head_p0];
  assign head_pred = pred_mem[head_p0];

  // Stage p0: acceptance, squash decision and next pointer state
  always_comb begin
    res_acc    = i_res_valid && (count_p0 != '0);
    mis        = res_acc && (head_pred != i_res_outcome);
    squash     = mis || i_flush;
    alloc_acc  = i_alloc_valid && o_alloc_ready && !squash;
    head_next  = head_p0 + PTR_W'(res_acc);
    tail_next  = tail_p0;
    count_next = count_p0;
    if (squash) begin
      // Both a mispredict (old head + 1) and a flush collapse tail onto the advanced head.
      tail_next  = head_next;
      count_next = '0;
    end else begin
      tail_next  = tail_p0 + PTR_W'(alloc_acc);
      count_next = count_p0 + (PTR_W+1)'(alloc_acc) - (PTR_W+1)'(res_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_p0  <= '0;
      tail_p0  <= '0;
      count_p0 <= '0;
    end else begin
      head_p0  <= head_next;
      tail_p0  <= tail_next;
      count_p0 <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && alloc_acc) begin
      pc_mem[tail_p0]   <= i_alloc_pc;
      pred_mem[tail_p0] <= i_alloc_prediction;
    end
  end

  // Stage p1: registered feedback beat; payload holds between beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_valid_p1   <= 1'b0;
      mispredict_p1 <= 1'b0;
      fb_pc_p1      <= '0;
      fb_pred_p1    <= NOT_TAKEN;
      fb_out_p1     <= NOT_TAKEN;
    end else begin
      fb_valid_p1   <= res_acc;
      mispredict_p1 <= mis;
      if (res_acc) begin
        fb_pc_p1   <= head_pc;
        fb_pred_p1 <= head_pred;
        fb_out_p1  <= i_res_outcome;
      end
    end
  end

  assign o_fb_valid      = fb_valid_p1;
  assign o_mispredict    = mispredict_p1;
  assign o_fb_pc         = fb_pc_p1;
  assign o_fb_prediction = fb_pred_p1;
  assign o_fb_outcome    = fb_out_p1;

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed bench for branch_feedback_queue: expected feedback beats are queued
// by the stimulus and checked by an independent monitor.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_feedback_queue;
  import mips_core_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   i_alloc_valid;
  logic [`ADDR_WIDTH-1:0] i_alloc_pc;
  BranchOutcome           i_alloc_prediction;
  logic                   o_alloc_ready;
  logic                   i_res_valid;
  BranchOutcome           i_res_outcome;
  logic                   i_flush;
  logic                   o_fb_valid;
  logic [`ADDR_WIDTH-1:0] o_fb_pc;
  BranchOutcome           o_fb_prediction;
  BranchOutcome           o_fb_outcome;
  logic                   o_mispredict;
  logic [$clog2(DEPTH):0] o_count;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [`ADDR_WIDTH-1:0] pc;
    BranchOutcome           pred;
    BranchOutcome           outc;
    logic                   mis;
  } fb_t;

  fb_t exp_q[$];

  branch_feedback_queue #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_alloc_valid      (i_alloc_valid),
    .i_alloc_pc         (i_alloc_pc),
    .i_alloc_prediction (i_alloc_prediction),
    .o_alloc_ready      (o_alloc_ready),
    .i_res_valid        (i_res_valid),
    .i_res_outcome      (i_res_outcome),
    .i_flush            (i_flush),
    .o_fb_valid         (o_fb_valid),
    .o_fb_pc            (o_fb_pc),
    .o_fb_prediction    (o_fb_prediction),
    .o_fb_outcome       (o_fb_outcome),
    .o_mispredict       (o_mispredict),
    .o_count            (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every feedback beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_fb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL fb_unexpected: got beat pc 0x%0h expected no beat", o_fb_pc);
      end else begin
        fb_t e;
        e = exp_q.pop_front();
        check("fb_pc", o_fb_pc, e.pc);
        check("fb_prediction", 32'(o_fb_prediction), 32'(e.pred));
        check("fb_outcome", 32'(o_fb_outcome), 32'(e.outc));
        check("fb_mispredict", 32'(o_mispredict), 32'(e.mis));
      end
    end else if (o_mispredict === 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL mispredict_no_valid: got mispredict=1 expected 0 without fb_valid");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_alloc_valid      = 1'b0;
    i_alloc_pc         = '0;
    i_alloc_prediction = NOT_TAKEN;
    i_res_valid        = 1'b0;
    i_res_outcome      = NOT_TAKEN;
    i_flush            = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input BranchOutcome p);
    i_alloc_valid      = 1'b1;
    i_alloc_pc         = pc;
    i_alloc_prediction = p;
    step();
    clear_inputs();
  endtask

  task automatic resolve(input BranchOutcome o);
    i_res_valid   = 1'b1;
    i_res_outcome = o;
    step();
    clear_inputs();
  endtask

  function automatic fb_t mk(input logic [31:0] pc, input BranchOutcome p, input BranchOutcome o);
    fb_t f;
    f.pc = pc; f.pred = p; f.outc = o; f.mis = (p != o);
    return f;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(o_count), 0);
    check({tag, "_ready"}, 32'(o_alloc_ready), 1);
    check({tag, "_fb_valid"}, 32'(o_fb_valid), 0);
    check({tag, "_mispredict"}, 32'(o_mispredict), 0);
    check({tag, "_fb_pc"}, o_fb_pc, 0);
    check({tag, "_fb_pred"}, 32'(o_fb_prediction), 32'(NOT_TAKEN));
    check({tag, "_fb_out"}, 32'(o_fb_outcome), 32'(NOT_TAKEN));
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("reset_idle");

    // Two correct predictions resolved back to back
    alloc(32'h100, TAKEN);
    alloc(32'h104, NOT_TAKEN);
    check("two_alloc_count", 32'(o_count), 2);
    exp_q.push_back(mk(32'h100, TAKEN, TAKEN));
    i_res_valid = 1'b1; i_res_outcome = TAKEN;
    step();
    exp_q.push_back(mk(32'h104, NOT_TAKEN, NOT_TAKEN));
    i_res_outcome = NOT_TAKEN;
    step();
    clear_inputs();
    check("two_res_count", 32'(o_count), 0);
    step();
    check("two_res_fb_drop", 32'(o_fb_valid), 0);

    // Fill with wrap (head=2); alloc while full plus resolve is dropped
    alloc(32'h200, TAKEN);
    alloc(32'h204, TAKEN);
    alloc(32'h208, TAKEN);
    alloc(32'h20C, TAKEN);
    check("full_count", 32'(o_count), 4);
    check("full_ready", 32'(o_alloc_ready), 0);
    exp_q.push_back(mk(32'h200, TAKEN, TAKEN));
    i_alloc_valid = 1'b1; i_alloc_pc = 32'h210; i_alloc_prediction = TAKEN;
    i_res_valid = 1'b1; i_res_outcome = TAKEN;
    step();
    clear_inputs();
    check("full_drop_count", 32'(o_count), 3);
    check("full_drop_ready", 32'(o_alloc_ready), 1);

    // Refill, then mispredict on the head squashes everything younger
    alloc(32'h214, NOT_TAKEN);
    check("refill_count", 32'(o_count), 4);
    exp_q.push_back(mk(32'h204, TAKEN, NOT_TAKEN));
    resolve(NOT_TAKEN);
    check("squash_count", 32'(o_count), 0);
    check("squash_ready", 32'(o_alloc_ready), 1);
    step();
    check("squash_pulse_end", 32'(o_mispredict), 0);
    alloc(32'h300, NOT_TAKEN);
    check("post_squash_count", 32'(o_count), 1);
    exp_q.push_back(mk(32'h300, NOT_TAKEN, NOT_TAKEN));
    resolve(NOT_TAKEN);
    check("post_squash_empty", 32'(o_count), 0);

    // Wrong-path alloc in the mispredict cycle is dropped
    alloc(32'h400, TAKEN);
    exp_q.push_back(mk(32'h400, TAKEN, NOT_TAKEN));
    i_alloc_valid = 1'b1; i_alloc_pc = 32'h404; i_alloc_prediction = TAKEN;
    i_res_valid = 1'b1; i_res_outcome = NOT_TAKEN;
    step();
    clear_inputs();
    check("squash_alloc_drop", 32'(o_count), 0);

    // Resolve on an empty queue is ignored; payload holds
    resolve(TAKEN);
    check("empty_res_count", 32'(o_count), 0);
    check("empty_res_fb_valid", 32'(o_fb_valid), 0);
    check("empty_res_hold_pc", o_fb_pc, 32'h400);
    check("empty_res_hold_out", 32'(o_fb_outcome), 32'(NOT_TAKEN));

    // Flush with same-cycle resolve and alloc
    alloc(32'h500, TAKEN);
    alloc(32'h504, NOT_TAKEN);
    alloc(32'h508, TAKEN);
    check("pre_flush_count", 32'(o_count), 3);
    exp_q.push_back(mk(32'h500, TAKEN, TAKEN));
    i_flush = 1'b1;
    i_res_valid = 1'b1; i_res_outcome = TAKEN;
    i_alloc_valid = 1'b1; i_alloc_pc = 32'h50C; i_alloc_prediction = NOT_TAKEN;
    step();
    clear_inputs();
    check("flush_count", 32'(o_count), 0);
    check("flush_ready", 32'(o_alloc_ready), 1);
    alloc(32'h600, TAKEN);
    exp_q.push_back(mk(32'h600, TAKEN, TAKEN));
    resolve(TAKEN);
    check("post_flush_count", 32'(o_count), 0);

    // Reset mid-stream overrides concurrent resolve/alloc
    alloc(32'h700, TAKEN);
    alloc(32'h704, NOT_TAKEN);
    check("pre_rst_count", 32'(o_count), 2);
    rst_n = 1'b0;
    i_res_valid = 1'b1; i_res_outcome = NOT_TAKEN;
    i_alloc_valid = 1'b1; i_alloc_pc = 32'h708; i_alloc_prediction = TAKEN;
    step();
    clear_inputs();
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_fb_valid", 32'(o_fb_valid), 0);
    check("post_rst_count", 32'(o_count), 0);

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1);
  end

endmodule
